// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the timer_cmp slot core: register addresses (decoded
// on addr[2:0]), ctrl bit positions, the stored ctrl register layout and a
// helper that builds the ctrl read-back word.
// -----------------------------------------------------------------------------
package timer_pkg;

  localparam logic [2:0] REG_CNT_LO  = 3'd0;
  localparam logic [2:0] REG_SNAP_HI = 3'd1;
  localparam logic [2:0] REG_CTRL    = 3'd2;
  localparam logic [2:0] REG_CMP_LO  = 3'd3;
  localparam logic [2:0] REG_CMP_HI  = 3'd4;
  localparam logic [2:0] REG_STATUS  = 3'd5;
  localparam logic [2:0] REG_PS      = 3'd6;

  localparam int CTRL_GO  = 0;
  localparam int CTRL_CLR = 1;
  localparam int CTRL_AR  = 2;
  localparam int CTRL_OS  = 3;
  localparam int CTRL_IE  = 4;

  // clear is a write-only pulse, so it has no storage here.
  typedef struct packed {
    logic irq_en;
    logic one_shot;
    logic auto_reload;
    logic go;
  } ctrl_t;

  function automatic logic [31:0] ctrl_rd(input ctrl_t c);
    logic [31:0] w;
    w           = '0;
    w[CTRL_GO]  = c.go;
    w[CTRL_AR]  = c.auto_reload;
    w[CTRL_OS]  = c.one_shot;
    w[CTRL_IE]  = c.irq_en;
    return w;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Divides the count-enable: tick is high for one cycle out of every
// (divisor+1) enabled cycles. Only built when TIMER_PRESCALE_EN is defined.
//   clk      in   core clock
//   reset    in   asynchronous active-high reset
//   en       in   advance the phase (timer go)
//   clr      in   zero the phase (takes priority over en)
//   divisor  in   PS_W-bit divide value
//   tick     out  count-enable event
// -----------------------------------------------------------------------------
`ifdef TIMER_PRESCALE_EN
module timer_prescaler #(
  parameter int PS_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  input  logic [PS_W-1:0] divisor,
  output logic            tick
);

  logic [PS_W-1:0] phase_q;
  logic [PS_W-1:0] phase_d;

  assign tick = en && (phase_q == divisor);

  // If the divisor is lowered below the current phase, the phase runs on and
  // wraps through zero before ticking again; only one long period results.
  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = (phase_q == divisor) ? '0 : phase_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

endmodule
`endif

// File: rtl/timer_cmp.sv
// -----------------------------------------------------------------------------
// timer_cmp
// Compare/reload timer slot core: CNT_W-bit counter with compare register,
// sticky match flag, level interrupt, auto-reload and one-shot modes, and a
// high-word snapshot taken whenever the low count word is read.
// Optional prescaler: define TIMER_PRESCALE_EN.
//   clk      in   core clock
//   reset    in   asynchronous active-high reset
//   cs       in   slot chip select
//   read     in   read strobe (latches snapshot on address 0)
//   write    in   write strobe
//   addr     in   5-bit register address (decoded on addr[2:0])
//   wr_data  in   32-bit write data
//   rd_data  out  32-bit read data, combinational from addr
//   irq      out  match_flag && irq_en
// -----------------------------------------------------------------------------
module timer_cmp
  import timer_pkg::*;
#(
  parameter int CNT_W = 48,
  parameter int PS_W  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);

  localparam int HI_W = CNT_W - 32;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cmp_q, cmp_d;
  logic [HI_W-1:0]  snap_q, snap_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             match_q, match_d;

  logic [2:0] reg_sel;
  logic       wr_en;
  logic       rd_en;
  logic       ctrl_wr;
  logic       clr_pulse;
  logic       tick;
  logic       hit;
  logic       unused_addr;

  assign reg_sel     = addr[2:0];
  assign unused_addr = ^addr[4:3];
  assign wr_en       = cs && write;
  assign rd_en       = cs && read;
  assign ctrl_wr     = wr_en && (reg_sel == REG_CTRL);
  assign clr_pulse   = ctrl_wr && wr_data[CTRL_CLR];
  assign hit         = (cnt_q == cmp_q);
  assign irq         = match_q && ctrl_q.irq_en;

`ifdef TIMER_PRESCALE_EN
  logic [PS_W-1:0] div_q;
  logic            ps_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (wr_en && (reg_sel == REG_PS)) begin
      div_q <= wr_data[PS_W-1:0];
    end
  end

  timer_prescaler #(.PS_W(PS_W)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (ctrl_q.go),
    .clr     (clr_pulse),
    .divisor (div_q),
    .tick    (ps_tick)
  );

  // clear suppresses the tick entirely, so no match can be taken with it.
  assign tick = ps_tick && !clr_pulse;
`else
  assign tick = ctrl_q.go && !clr_pulse;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    cmp_d   = cmp_q;
    snap_d  = snap_q;
    ctrl_d  = ctrl_q;
    match_d = match_q;

    if (ctrl_wr) begin
      ctrl_d.go          = wr_data[CTRL_GO];
      ctrl_d.auto_reload = wr_data[CTRL_AR];
      ctrl_d.one_shot    = wr_data[CTRL_OS];
      ctrl_d.irq_en      = wr_data[CTRL_IE];
    end
    if (wr_en && (reg_sel == REG_CMP_LO)) cmp_d[31:0]       = wr_data;
    if (wr_en && (reg_sel == REG_CMP_HI)) cmp_d[CNT_W-1:32] = wr_data[HI_W-1:0];

    // W1C is applied first so that a match in the same cycle overrides it.
    if (wr_en && (reg_sel == REG_STATUS) && wr_data[0]) match_d = 1'b0;

    // High word captured with the low word the reader sees this cycle.
    if (rd_en && (reg_sel == REG_CNT_LO)) snap_d = cnt_q[CNT_W-1:32];

    if (clr_pulse) begin
      cnt_d = '0;
    end else if (tick) begin
      if (hit) begin
        match_d = 1'b1;
        cnt_d   = ctrl_q.auto_reload ? '0 : cnt_q + CNT_W'(1);
        // A software write to ctrl in the same cycle keeps the written go.
        if (ctrl_q.one_shot && !ctrl_wr) ctrl_d.go = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      cmp_q   <= '1;
      snap_q  <= '0;
      ctrl_q  <= '0;
      match_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      snap_q  <= snap_d;
      ctrl_q  <= ctrl_d;
      match_q <= match_d;
    end
  end

  logic [31:0] snap_ext;
  logic [31:0] cmp_hi_ext;
  logic [31:0] ps_ext;

  always_comb begin
    snap_ext             = '0;
    snap_ext[HI_W-1:0]   = snap_q;
    cmp_hi_ext           = '0;
    cmp_hi_ext[HI_W-1:0] = cmp_q[CNT_W-1:32];
    ps_ext               = '0;
`ifdef TIMER_PRESCALE_EN
    ps_ext[PS_W-1:0]     = div_q;
`endif
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_CNT_LO:  rd_data = cnt_q[31:0];
      REG_SNAP_HI: rd_data = snap_ext;
      REG_CTRL:    rd_data = ctrl_rd(ctrl_q);
      REG_CMP_LO:  rd_data = cmp_q[31:0];
      REG_CMP_HI:  rd_data = cmp_hi_ext;
      REG_STATUS:  rd_data = {31'b0, match_q};
      REG_PS:      rd_data = ps_ext;
      default:     rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_cmp.sv
// -----------------------------------------------------------------------------
// tb_timer_cmp
// Directed bench for timer_cmp (CNT_W=48). Covers the prescaler path when
// TIMER_PRESCALE_EN is defined, otherwise the disabled address 6.
// -----------------------------------------------------------------------------
module tb_timer_cmp;

  localparam int CNT_W = 48;
  localparam int PS_W  = 16;

  localparam logic [4:0] A_CNT  = 5'd0;
  localparam logic [4:0] A_SNAP = 5'd1;
  localparam logic [4:0] A_CTRL = 5'd2;
  localparam logic [4:0] A_CMPL = 5'd3;
  localparam logic [4:0] A_CMPH = 5'd4;
  localparam logic [4:0] A_STAT = 5'd5;
  localparam logic [4:0] A_PS   = 5'd6;
  localparam logic [4:0] A_RSVD = 5'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_cmp #(.CNT_W(CNT_W), .PS_W(PS_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .irq     (irq)
  );

  // All access tasks are entered at (or just after) a falling edge and
  // return at the next falling edge; the access is sampled on the rise between.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; read = 1'b0; addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
    #1 d = rd_data;
    @(negedge clk);
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic peek_cnt(output logic [31:0] d);
    cs = 1'b0; addr = A_CNT;
    #1 d = rd_data;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    rd(A_CNT, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", v); end
    rd(A_SNAP, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_snap: got %h want 0", v); end
    rd(A_CTRL, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", v); end
    rd(A_CMPL, v); checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_lo: got %h want ffffffff", v); end
    rd(A_CMPH, v); checks++; if (v !== 32'h0000_FFFF) begin errors++; $display("FAIL reset_cmp_hi: got %h want 0000ffff", v); end
    rd(A_STAT, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", v); end
    rd(A_PS, v);   checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_ps: got %h want 0", v); end
  endtask

  task automatic test_count;
    logic [31:0] v;
    wr(A_CTRL, 32'h01);
    repeat (10) @(negedge clk);
    rd(A_CNT, v);  checks++; if (v !== 32'd10) begin errors++; $display("FAIL count10: got %0d want 10", v); end
    rd(A_SNAP, v); checks++; if (v !== 32'd0)  begin errors++; $display("FAIL count10_snap: got %h want 0", v); end
  endtask

  task automatic test_snapshot;
    logic [31:0] v;
    force dut.cnt_q = 48'h0000_FFFF_FFFF;
    rd(A_CNT, v);  checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL snap_lo: got %h want ffffffff", v); end
    release dut.cnt_q;
    rd(A_SNAP, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL snap_hi0: got %h want 0", v); end
    rd(A_CNT, v);
    rd(A_SNAP, v); checks++; if (v !== 32'h1) begin errors++; $display("FAIL snap_hi1: got %h want 1", v); end
    wr(A_CTRL, 32'h02);
  endtask

  task automatic test_auto_reload;
    logic [31:0] v;
    bit found;
    wr(A_CTRL, 32'h02);
    wr(A_STAT, 32'h1);
    wr(A_CMPL, 32'd5);
    wr(A_CMPH, 32'd0);
    wr(A_CTRL, 32'h15);
    for (int i = 0; i < 12; i++) begin
      peek_cnt(v);
      checks++;
      if (v !== 32'(i % 6)) begin errors++; $display("FAIL ar_seq[%0d]: got %0d want %0d", i, v, i % 6); end
      if (i == 5) begin checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ar_irq_pre: got %b want 0", irq); end end
      if (i == 6) begin checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ar_irq_post: got %b want 1", irq); end end
      @(negedge clk);
    end
    wr(A_STAT, 32'h1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ar_w1c: got %b want 0", irq); end
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      peek_cnt(v);
      if (v == 32'd5) found = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL ar_wait5: got timeout want count 5"); end
    wr(A_STAT, 32'h1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ar_w1c_vs_set: got %b want 1", irq); end
    peek_cnt(v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL ar_wrap: got %0d want 0", v); end
  endtask

  task automatic test_one_shot;
    logic [31:0] v;
    wr(A_CTRL, 32'h02);
    wr(A_STAT, 32'h1);
    wr(A_CMPL, 32'd3);
    wr(A_CTRL, 32'h09);
    repeat (10) @(negedge clk);
    rd(A_CNT, v);  checks++; if (v !== 32'd4)  begin errors++; $display("FAIL os_cnt: got %0d want 4", v); end
    rd(A_CTRL, v); checks++; if (v !== 32'h08) begin errors++; $display("FAIL os_ctrl: got %h want 08", v); end
    rd(A_STAT, v); checks++; if (v !== 32'h1)  begin errors++; $display("FAIL os_flag: got %h want 1", v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL os_irq: got %b want 0", irq); end
  endtask

  task automatic test_clear;
    logic [31:0] v;
    bit found;
    wr(A_CMPL, 32'd1000);
    wr(A_CTRL, 32'h02);
    wr(A_CTRL, 32'h01);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      peek_cnt(v);
      if (v == 32'd100) found = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL clr_wait100: got timeout want count 100"); end
    wr(A_CTRL, 32'h03);
    peek_cnt(v); checks++; if (v !== 32'd0) begin errors++; $display("FAIL clr_zero: got %0d want 0", v); end
    @(negedge clk);
    peek_cnt(v); checks++; if (v !== 32'd1) begin errors++; $display("FAIL clr_resume: got %0d want 1", v); end
    rd(A_STAT, v); checks++; if (v !== 32'h1)  begin errors++; $display("FAIL clr_flag: got %h want 1", v); end
    rd(A_CTRL, v); checks++; if (v !== 32'h01) begin errors++; $display("FAIL clr_ctrl: got %h want 01", v); end
  endtask

  task automatic test_prescale;
    logic [31:0] v;
    wr(A_CTRL, 32'h02);
`ifdef TIMER_PRESCALE_EN
    wr(A_PS, 32'd3);
    wr(A_CTRL, 32'h01);
    repeat (40) @(negedge clk);
    peek_cnt(v); checks++; if (v !== 32'd10) begin errors++; $display("FAIL ps_cnt: got %0d want 10", v); end
    rd(A_PS, v); checks++; if (v !== 32'd3)  begin errors++; $display("FAIL ps_reg: got %0d want 3", v); end
`else
    wr(A_PS, 32'h7);
    rd(A_PS, v); checks++; if (v !== 32'd0) begin errors++; $display("FAIL ps_absent: got %h want 0", v); end
`endif
    wr(A_RSVD, 32'hDEAD_BEEF);
    rd(A_RSVD, v); checks++; if (v !== 32'd0) begin errors++; $display("FAIL rsvd: got %h want 0", v); end
    wr(A_CTRL, 32'h11);
  endtask

  task automatic test_async_reset;
    logic [31:0] v;
    wr(A_CMPL, 32'd2);
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    peek_cnt(v); checks++; if (v !== 32'd0) begin errors++; $display("FAIL arst_cnt: got %0d want 0", v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL arst_irq: got %b want 0", irq); end
    addr = A_CTRL; #1;
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL arst_ctrl: got %h want 0", rd_data); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b0;
    @(negedge clk);
    test_count;
    test_snapshot;
    test_auto_reload;
    test_one_shot;
    test_clear;
    test_prescale;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
